// File: rtl/tree_arb_pkg.sv
// Shared types and elaboration-time sizing helpers for the binary-tree round-robin arbiter.
package tree_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int levels(input int n);
        return idx_w(n);
    endfunction

    function automatic int npad(input int n);
        return 1 << idx_w(n);
    endfunction

endpackage

// File: rtl/tree_arb_node.sv
// Two-input round-robin node: p=0 favours left, p=1 favours right; p flips only when a grant passes.
module tree_arb_node
    import tree_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_l,
    input  logic req_r,
    input  logic upd_en,
    output logic win_l,
    output logic win_r,
    output logic req_up
);

    logic p_q, p_d;

    always_comb begin
        win_l  = req_l & (~req_r | ~p_q);
        win_r  = req_r & (~req_l | p_q);
        req_up = req_l | req_r;
        p_d    = p_q;
        // A left win hands priority to the right, a right win hands it back.
        if (upd_en) begin
            p_d = win_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/tree_rr_arbiter.sv
// N-requester tree round-robin arbiter with registered one-hot/index grant, grant hold and tenure limit.
module tree_rr_arbiter
    import tree_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 8,
    parameter  int HOLD     = 1,
    parameter  int MAX_HOLD = 0,
    localparam int IDX_W    = idx_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    localparam int LEVELS = levels(NUM_REQ);
    localparam int NPAD   = npad(NUM_REQ);
    localparam int CNT_W  = idx_w(MAX_HOLD + 2);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NPAD-1:0]    req_pad, own_pad, others, arb_req, leaf_gnt;
    logic [IDX_W-1:0]   leaf_idx;
    logic               own_req, forced, rel, load_en;

    always_comb begin
        req_pad = '0;
        own_pad = '0;
        req_pad[NUM_REQ-1:0] = req;
        own_pad[NUM_REQ-1:0] = gnt_q;
    end

    assign own_req = req_pad[gnt_idx_q];
    assign forced  = (MAX_HOLD != 0) && (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign rel     = !en || !own_req || forced;
    assign others  = req_pad & ~own_pad;
    // On a forced release the owner sits out unless nobody else is asking.
    assign arb_req = (forced && (|others)) ? others : req_pad;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NN = 1 << l;
        logic [NN-1:0] req_up, gin, win_l, win_r, ch_l, ch_r;
        for (genvar k = 0; k < NN; k++) begin : g_node
            if (l == LEVELS - 1) begin : g_leaf
                assign ch_l[k]           = arb_req[2*k];
                assign ch_r[k]           = arb_req[2*k+1];
                assign leaf_gnt[2*k]     = gin[k] & win_l[k];
                assign leaf_gnt[2*k+1]   = gin[k] & win_r[k];
            end else begin : g_inner
                assign ch_l[k] = g_lvl[l+1].req_up[2*k];
                assign ch_r[k] = g_lvl[l+1].req_up[2*k+1];
            end
            if (l == 0) begin : g_root
                assign gin[k] = req_up[k];
            end else if (k % 2 == 0) begin : g_lchild
                assign gin[k] = g_lvl[l-1].gin[k/2] & g_lvl[l-1].win_l[k/2];
            end else begin : g_rchild
                assign gin[k] = g_lvl[l-1].gin[k/2] & g_lvl[l-1].win_r[k/2];
            end
            tree_arb_node u_node (
                .clk    (clk),
                .rst_n  (rst_n),
                .req_l  (ch_l[k]),
                .req_r  (ch_r[k]),
                .upd_en (load_en & gin[k]),
                .win_l  (win_l[k]),
                .win_r  (win_r[k]),
                .req_up (req_up[k])
            );
        end
    end

    always_comb begin
        leaf_idx = '0;
        for (int i = 0; i < NPAD; i++) begin
            if (leaf_gnt[i]) begin
                leaf_idx = leaf_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        cnt_d     = cnt_q;
        load_en   = 1'b0;
        if (HOLD == 0) begin
            state_d = IDLE;
            if (en) begin
                load_en   = 1'b1;
                gnt_d     = leaf_gnt[NUM_REQ-1:0];
                gnt_vld_d = |arb_req;
                if (|arb_req) begin
                    gnt_idx_d = leaf_idx;
                end
            end else begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && (|arb_req)) begin
                        load_en   = 1'b1;
                        gnt_d     = leaf_gnt[NUM_REQ-1:0];
                        gnt_idx_d = leaf_idx;
                        gnt_vld_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = GRANT;
                    end else begin
                        gnt_d     = '0;
                        gnt_vld_d = 1'b0;
                    end
                end
                GRANT: begin
                    if (!rel) begin
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (en && (|arb_req)) begin
                        // Re-arbitrate on release without an idle bubble.
                        load_en   = 1'b1;
                        gnt_d     = leaf_gnt[NUM_REQ-1:0];
                        gnt_idx_d = leaf_idx;
                        gnt_vld_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        gnt_d     = '0;
                        gnt_vld_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_tree_rr_arbiter.sv
// Directed bench for tree_rr_arbiter across four parameterisations sharing one clock and reset.
module tb_tree_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic       h0_en, h1_en, mh_en, p5_en;
    logic [3:0] h0_req, h1_req, mh_req;
    logic [4:0] p5_req;
    logic [3:0] h0_gnt, h1_gnt, mh_gnt;
    logic [4:0] p5_gnt;
    logic [1:0] h0_idx, h1_idx, mh_idx;
    logic [2:0] p5_idx;
    logic       h0_vld, h1_vld, mh_vld, p5_vld;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tree_rr_arbiter #(.NUM_REQ(4), .HOLD(0), .MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .en(h0_en), .req(h0_req),
        .gnt(h0_gnt), .gnt_idx(h0_idx), .gnt_vld(h0_vld)
    );

    tree_rr_arbiter #(.NUM_REQ(4), .HOLD(1), .MAX_HOLD(0)) u_h1 (
        .clk(clk), .rst_n(rst_n), .en(h1_en), .req(h1_req),
        .gnt(h1_gnt), .gnt_idx(h1_idx), .gnt_vld(h1_vld)
    );

    tree_rr_arbiter #(.NUM_REQ(4), .HOLD(1), .MAX_HOLD(3)) u_mh (
        .clk(clk), .rst_n(rst_n), .en(mh_en), .req(mh_req),
        .gnt(mh_gnt), .gnt_idx(mh_idx), .gnt_vld(mh_vld)
    );

    tree_rr_arbiter #(.NUM_REQ(5), .HOLD(1), .MAX_HOLD(0)) u_p5 (
        .clk(clk), .rst_n(rst_n), .en(p5_en), .req(p5_req),
        .gnt(p5_gnt), .gnt_idx(p5_idx), .gnt_vld(p5_vld)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t1_idx[6] = '{0, 2, 1, 3, 0, 2};
    int t3_idx[9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};

    initial begin
        rst_n  = 1'b0;
        h0_en  = 1'b0; h1_en = 1'b0; mh_en = 1'b0; p5_en = 1'b0;
        h0_req = '0;   h1_req = '0;  mh_req = '0;  p5_req = '0;
        #12;
        check("rst_h0_gnt", 32'(h0_gnt), 32'd0);
        check("rst_h0_idx", 32'(h0_idx), 32'd0);
        check("rst_h0_vld", 32'(h0_vld), 32'd0);
        check("rst_p5_gnt", 32'(p5_gnt), 32'd0);
        check("rst_p5_vld", 32'(p5_vld), 32'd0);
        rst_n = 1'b1;

        // HOLD=0 rotation with all four requesting
        h0_req = 4'b1111;
        h0_en  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_idx", 32'(h0_idx), 32'(t1_idx[i]));
            check("rr_gnt", 32'(h0_gnt), 32'd1 << t1_idx[i]);
            check("rr_vld", 32'(h0_vld), 32'd1);
        end

        // HOLD=1: owner keeps grant, then hand-over without a gap
        h1_en  = 1'b1;
        h1_req = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_gnt", 32'(h1_gnt), 32'b0010);
            check("hold_vld", 32'(h1_vld), 32'd1);
        end
        h1_req = 4'b1000;
        tick();
        check("handover_gnt", 32'(h1_gnt), 32'b1000);
        check("handover_idx", 32'(h1_idx), 32'd3);
        check("handover_vld", 32'(h1_vld), 32'd1);
        h1_req = 4'b0101;
        tick();
        check("drop_new_gnt", 32'(h1_gnt), 32'b0001);
        check("drop_new_idx", 32'(h1_idx), 32'd0);
        h1_req = 4'b0100;
        tick();
        check("to2_idx", 32'(h1_idx), 32'd2);
        h1_en = 1'b0;
        tick();
        check("en_off_gnt", 32'(h1_gnt), 32'd0);
        check("en_off_vld", 32'(h1_vld), 32'd0);
        check("en_off_idx", 32'(h1_idx), 32'd2);
        h1_en  = 1'b1;
        h1_req = 4'b1111;
        tick();
        check("en_on_gnt", 32'(h1_gnt), 32'b0010);
        check("en_on_idx", 32'(h1_idx), 32'd1);

        // MAX_HOLD=3 tenure alternation, then sole requester re-grant
        mh_en  = 1'b1;
        mh_req = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("tenure_idx", 32'(mh_idx), 32'(t3_idx[i]));
            check("tenure_gnt", 32'(mh_gnt), 32'd1 << t3_idx[i]);
        end
        mh_req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("sole_gnt", 32'(mh_gnt), 32'b0001);
            check("sole_vld", 32'(mh_vld), 32'd1);
        end

        // NUM_REQ=5 padded tree
        p5_en  = 1'b1;
        p5_req = 5'b10000;
        tick();
        check("pad_gnt", 32'(p5_gnt), 32'b10000);
        check("pad_idx", 32'(p5_idx), 32'd4);
        check("pad_vld", 32'(p5_vld), 32'd1);
        p5_req = 5'b00000;
        tick();
        check("pad_rel_gnt", 32'(p5_gnt), 32'd0);
        check("pad_rel_vld", 32'(p5_vld), 32'd0);
        check("pad_rel_idx", 32'(p5_idx), 32'd4);

        // Asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(h1_gnt), 32'd0);
        check("arst_vld", 32'(h1_vld), 32'd0);
        check("arst_idx", 32'(h1_idx), 32'd0);
        check("arst_h0_vld", 32'(h0_vld), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_h0_idx", 32'(h0_idx), 32'd0);
        check("post_rst_h0_gnt", 32'(h0_gnt), 32'b0001);
        check("post_rst_h1_idx", 32'(h1_idx), 32'd0);

        // HOLD=0 with no requests
        h0_req = 4'b0000;
        tick();
        check("h0_idle_gnt", 32'(h0_gnt), 32'd0);
        check("h0_idle_vld", 32'(h0_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
